// File: rtl/cop0_exception_sequencer.sv
// COP0 exception entry / ERET return sequencer.
// Performs one COP0 register access per cycle through a single read port
// and a single write port. Finishes with a one-cycle fetch redirect.
module cop0_exception_sequencer #(
    parameter logic [11:0] VECTOR_OFFSET = 12'h180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic        exc_has_badvaddr,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_valid,
    output logic        busy,
    output logic        cop0_we,
    output logic [4:0]  cop0_write_rd,
    output logic [2:0]  cop0_write_sel,
    output logic [31:0] cop0_din,
    output logic [4:0]  cop0_read_rd,
    output logic [2:0]  cop0_read_sel,
    input  logic [31:0] cop0_dout,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // COP0 register numbers (rd); EBase is the only register using sel 1.
    localparam logic [4:0] RD_BADVADDR = 5'd8;
    localparam logic [4:0] RD_STATUS   = 5'd12;
    localparam logic [4:0] RD_CAUSE    = 5'd13;
    localparam logic [4:0] RD_EPC      = 5'd14;
    localparam logic [4:0] RD_EBASE    = 5'd15;
    localparam logic [4:0] RD_ERROREPC = 5'd30;

    typedef enum logic [3:0] {
        IDLE,
        X_RD_STATUS,
        X_WR_EPC,
        X_WR_BADV,
        X_RD_CAUSE,
        X_WR_CAUSE,
        X_WR_STATUS,
        X_RD_EBASE,
        E_RD_STATUS,
        E_WR_STATUS,
        E_RD_EPC,
        REDIRECT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] status_reg, status_next;

    // Latched exception request
    logic [4:0]  exc_code_reg;
    logic [31:0] exc_pc_reg;
    logic        exc_ds_reg;
    logic        exc_has_bv_reg;
    logic [31:0] exc_bv_reg;

    // Registered outputs and their next values
    logic        busy_reg, busy_next;
    logic        we_reg, we_next;
    logic [4:0]  wr_rd_reg, wr_rd_next;
    logic [2:0]  wr_sel_reg, wr_sel_next;
    logic [31:0] din_reg, din_next;
    logic [4:0]  rd_rd_reg, rd_rd_next;
    logic [2:0]  rd_sel_reg, rd_sel_next;
    logic        redir_reg, redir_next;
    logic [31:0] redir_pc_reg, redir_pc_next;

    // Next state, write data, and COP0 control decoded from the next state
    // so that every output is a register aligned with the state it belongs to.
    always_comb begin
        state_next    = state_reg;
        status_next   = status_reg;
        din_next      = '0;
        redir_pc_next = redir_pc_reg;

        case (state_reg)
            IDLE: begin
                if (exc_valid) begin
                    state_next = X_RD_STATUS;
                end else if (eret_valid) begin
                    state_next = E_RD_STATUS;
                end
            end
            X_RD_STATUS: begin
                status_next = cop0_dout;
                if (!cop0_dout[1]) begin
                    state_next = X_WR_EPC;
                    din_next   = exc_ds_reg ? (exc_pc_reg - 32'd4) : exc_pc_reg;
                end else if (exc_has_bv_reg) begin
                    state_next = X_WR_BADV;
                    din_next   = exc_bv_reg;
                end else begin
                    state_next = X_RD_CAUSE;
                end
            end
            X_WR_EPC: begin
                if (exc_has_bv_reg) begin
                    state_next = X_WR_BADV;
                    din_next   = exc_bv_reg;
                end else begin
                    state_next = X_RD_CAUSE;
                end
            end
            X_WR_BADV: state_next = X_RD_CAUSE;
            X_RD_CAUSE: begin
                // BD only updates when this is not a nested exception.
                state_next = X_WR_CAUSE;
                din_next   = {(status_reg[1] ? cop0_dout[31] : exc_ds_reg),
                              cop0_dout[30:7], exc_code_reg, cop0_dout[1:0]};
            end
            X_WR_CAUSE: begin
                state_next = X_WR_STATUS;
                din_next   = status_reg | 32'h2;
            end
            X_WR_STATUS: state_next = X_RD_EBASE;
            X_RD_EBASE: begin
                state_next    = REDIRECT;
                redir_pc_next = {cop0_dout[31:12], VECTOR_OFFSET};
            end
            E_RD_STATUS: begin
                status_next = cop0_dout;
                state_next  = E_WR_STATUS;
                din_next    = cop0_dout[2] ? (cop0_dout & ~32'h4) : (cop0_dout & ~32'h2);
            end
            E_WR_STATUS: state_next = E_RD_EPC;
            E_RD_EPC: begin
                state_next    = REDIRECT;
                redir_pc_next = cop0_dout;
            end
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        we_next     = 1'b0;
        wr_rd_next  = '0;
        wr_sel_next = '0;
        rd_rd_next  = '0;
        rd_sel_next = '0;
        redir_next  = 1'b0;
        busy_next   = (state_next != IDLE);

        case (state_next)
            X_RD_STATUS, E_RD_STATUS: rd_rd_next = RD_STATUS;
            X_WR_EPC: begin
                we_next    = 1'b1;
                wr_rd_next = RD_EPC;
            end
            X_WR_BADV: begin
                we_next    = 1'b1;
                wr_rd_next = RD_BADVADDR;
            end
            X_RD_CAUSE: rd_rd_next = RD_CAUSE;
            X_WR_CAUSE: begin
                we_next    = 1'b1;
                wr_rd_next = RD_CAUSE;
            end
            X_WR_STATUS, E_WR_STATUS: begin
                we_next    = 1'b1;
                wr_rd_next = RD_STATUS;
            end
            X_RD_EBASE: begin
                rd_rd_next  = RD_EBASE;
                rd_sel_next = 3'd1;
            end
            E_RD_EPC: rd_rd_next = status_next[2] ? RD_ERROREPC : RD_EPC;
            REDIRECT: redir_next = 1'b1;
            default: ;
        endcase
    end

    // State, latched Status, and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            status_reg   <= '0;
            busy_reg     <= 1'b0;
            we_reg       <= 1'b0;
            wr_rd_reg    <= '0;
            wr_sel_reg   <= '0;
            din_reg      <= '0;
            rd_rd_reg    <= '0;
            rd_sel_reg   <= '0;
            redir_reg    <= 1'b0;
            redir_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            status_reg   <= status_next;
            busy_reg     <= busy_next;
            we_reg       <= we_next;
            wr_rd_reg    <= wr_rd_next;
            wr_sel_reg   <= wr_sel_next;
            din_reg      <= din_next;
            rd_rd_reg    <= rd_rd_next;
            rd_sel_reg   <= rd_sel_next;
            redir_reg    <= redir_next;
            redir_pc_reg <= redir_pc_next;
        end
    end

    // Capture the exception request on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_code_reg   <= '0;
            exc_pc_reg     <= '0;
            exc_ds_reg     <= 1'b0;
            exc_has_bv_reg <= 1'b0;
            exc_bv_reg     <= '0;
        end else if (state_reg == IDLE && exc_valid) begin
            exc_code_reg   <= exc_code;
            exc_pc_reg     <= exc_pc;
            exc_ds_reg     <= exc_in_delay_slot;
            exc_has_bv_reg <= exc_has_badvaddr;
            exc_bv_reg     <= exc_badvaddr;
        end
    end

    assign busy           = busy_reg;
    assign cop0_we        = we_reg;
    assign cop0_write_rd  = wr_rd_reg;
    assign cop0_write_sel = wr_sel_reg;
    assign cop0_din       = din_reg;
    assign cop0_read_rd   = rd_rd_reg;
    assign cop0_read_sel  = rd_sel_reg;
    assign redirect_valid = redir_reg;
    assign redirect_pc    = redir_pc_reg;

endmodule

// File: tb/tb_cop0_exception_sequencer.sv
// Bench for cop0_exception_sequencer: a COP0 register file model, directed
// stimulus, and a scoreboard of expected writes/redirects with cycle stamps.
module tb_cop0_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic        exc_has_badvaddr;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic        busy;
    logic        cop0_we;
    logic [4:0]  cop0_write_rd;
    logic [2:0]  cop0_write_sel;
    logic [31:0] cop0_din;
    logic [4:0]  cop0_read_rd;
    logic [2:0]  cop0_read_sel;
    logic [31:0] cop0_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    cop0_exception_sequencer #(.VECTOR_OFFSET(12'h180)) dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_in_delay_slot(exc_in_delay_slot), .exc_has_badvaddr(exc_has_badvaddr),
        .exc_badvaddr(exc_badvaddr), .eret_valid(eret_valid), .busy(busy),
        .cop0_we(cop0_we), .cop0_write_rd(cop0_write_rd), .cop0_write_sel(cop0_write_sel),
        .cop0_din(cop0_din), .cop0_read_rd(cop0_read_rd), .cop0_read_sel(cop0_read_sel),
        .cop0_dout(cop0_dout), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Register file addresses as {rd, sel}
    localparam logic [7:0] A_BADV   = {5'd8,  3'd0};
    localparam logic [7:0] A_STATUS = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE  = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC    = {5'd14, 3'd0};
    localparam logic [7:0] A_EBASE  = {5'd15, 3'd1};
    localparam logic [7:0] A_ERREPC = {5'd30, 3'd0};

    // COP0 register file: combinational read, write visible next cycle
    logic [31:0] regs [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    assign cop0_dout = regs[{cop0_read_rd, cop0_read_sel}];
    always @(posedge clk) begin
        if (cop0_we) regs[{cop0_write_rd, cop0_write_sel}] <= cop0_din;
        if (poke_en) regs[poke_addr] <= poke_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        redir;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  c0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [31:0] data);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        tick(1);
        poke_en   = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] addr, input logic [31:0] data, input int c);
        exp_q.push_back('{redir: 1'b0, addr: addr, data: data, cyc: c});
    endtask

    task automatic push_redir(input logic [31:0] pc, input int c);
        exp_q.push_back('{redir: 1'b1, addr: 8'd0, data: pc, cyc: c});
    endtask

    task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                           input logic hbv, input logic [31:0] bv);
        exc_code          = code;
        exc_pc            = pc;
        exc_in_delay_slot = ds;
        exc_has_badvaddr  = hbv;
        exc_badvaddr      = bv;
        exc_valid         = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin : bounded_run
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; exc_valid = 1'b0; eret_valid = 1'b0;
        exc_code = '0; exc_pc = '0; exc_in_delay_slot = 1'b0;
        exc_has_badvaddr = 1'b0; exc_badvaddr = '0;

        // Scoreboard monitor: every COP0 write or redirect pops one expectation
        fork
            forever begin : monitor
                ev_t obs, e;
                @(negedge clk);
                if (cop0_we || redirect_valid) begin
                    obs.redir = redirect_valid;
                    obs.addr  = redirect_valid ? 8'd0 : {cop0_write_rd, cop0_write_sel};
                    obs.data  = redirect_valid ? redirect_pc : cop0_din;
                    obs.cyc   = cyc;
                    $display("cyc %0d %s addr=%h data=%h", cyc,
                             redirect_valid ? "redirect" : "write", obs.addr, obs.data);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $error("FAIL unexpected_event observed=%h expected=none", obs);
                    end else begin
                        e = exp_q.pop_front();
                        assert (obs === e) else begin
                            errors++;
                            $error("FAIL event observed=%h expected=%h", obs, e);
                        end
                    end
                end
            end
        join_none

        tick(1);
        poke(A_STATUS, 32'h0040_0004);
        poke(A_ERREPC, 32'hBFC0_0100);
        poke(A_EBASE,  32'h8000_0000);
        poke(A_CAUSE,  32'h0);
        poke(A_EPC,    32'h0);
        poke(A_BADV,   32'h0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_we",      {31'd0, cop0_we}, 32'd0);
        chk("rst_redir",   {31'd0, redirect_valid}, 32'd0);
        chk("rst_pc",      redirect_pc, 32'd0);
        chk("rst_din",     cop0_din, 32'd0);
        chk("rst_rdsel",   {16'd0, cop0_read_rd, cop0_read_sel, cop0_write_rd, cop0_write_sel}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Test 1: ERET with ERL set returns to ErrorEPC
        $display("test1 eret from reset");
        eret_valid = 1'b1; c0 = cyc;
        push_wr(A_STATUS, 32'h0040_0000, c0 + 2);
        push_redir(32'hBFC0_0100, c0 + 4);
        tick(1); eret_valid = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_idle("t1_idle");
        chk("t1_drain", exp_q.size(), 32'd0);

        // Test 2: first-level exception with BadVAddr
        $display("test2 exception with badvaddr");
        poke(A_CAUSE, 32'h0);
        set_exc(5'd4, 32'h8000_1000, 1'b0, 1'b1, 32'h1234_5679); c0 = cyc;
        push_wr(A_EPC,    32'h8000_1000, c0 + 2);
        push_wr(A_BADV,   32'h1234_5679, c0 + 3);
        push_wr(A_CAUSE,  32'h0000_0010, c0 + 5);
        push_wr(A_STATUS, 32'h0040_0002, c0 + 6);
        push_redir(32'h8000_0180, c0 + 8);
        tick(1); exc_valid = 1'b0;
        wait_idle("t2_idle");
        chk("t2_drain", exp_q.size(), 32'd0);

        // Test 3: delay-slot exception, no BadVAddr
        $display("test3 delay slot exception");
        poke(A_STATUS, 32'h0040_0000);
        poke(A_CAUSE,  32'h0000_0400);
        set_exc(5'd8, 32'h8000_2004, 1'b1, 1'b0, 32'hDEAD_BEEF); c0 = cyc;
        push_wr(A_EPC,    32'h8000_2000, c0 + 2);
        push_wr(A_CAUSE,  32'h8000_0420, c0 + 4);
        push_wr(A_STATUS, 32'h0040_0002, c0 + 5);
        push_redir(32'h8000_0180, c0 + 7);
        tick(1); exc_valid = 1'b0;
        wait_idle("t3_idle");
        chk("t3_drain", exp_q.size(), 32'd0);

        // Test 4: nested exception keeps EPC and BD
        $display("test4 nested exception");
        poke(A_CAUSE, 32'h8000_0000);
        set_exc(5'd12, 32'h8000_5000, 1'b0, 1'b0, 32'h0); c0 = cyc;
        push_wr(A_CAUSE,  32'h8000_0030, c0 + 3);
        push_wr(A_STATUS, 32'h0040_0002, c0 + 4);
        push_redir(32'h8000_0180, c0 + 6);
        tick(1); exc_valid = 1'b0;
        wait_idle("t4_idle");
        chk("t4_drain", exp_q.size(), 32'd0);
        chk("t4_epc_kept", regs[A_EPC], 32'h8000_2000);

        // Test 5: simultaneous exception and ERET; ERET runs right after
        $display("test5 exception beats eret");
        poke(A_STATUS, 32'h0040_0000);
        poke(A_CAUSE,  32'h0);
        set_exc(5'd0, 32'h8000_3000, 1'b0, 1'b0, 32'h0);
        eret_valid = 1'b1; c0 = cyc;
        push_wr(A_EPC,    32'h8000_3000, c0 + 2);
        push_wr(A_CAUSE,  32'h0000_0000, c0 + 4);
        push_wr(A_STATUS, 32'h0040_0002, c0 + 5);
        push_redir(32'h8000_0180, c0 + 7);
        push_wr(A_STATUS, 32'h0040_0000, c0 + 10);
        push_redir(32'h8000_3000, c0 + 12);
        tick(1); exc_valid = 1'b0;
        tick(7);
        chk("t5_idle_gap", {31'd0, busy}, 32'd0);
        tick(1); eret_valid = 1'b0;
        chk("t5_eret_busy", {31'd0, busy}, 32'd1);
        wait_idle("t5_idle");
        chk("t5_drain", exp_q.size(), 32'd0);

        // Test 6: reset during cycle 3 aborts the sequence
        $display("test6 reset mid exception");
        poke(A_STATUS, 32'h0040_0000);
        poke(A_CAUSE,  32'h0);
        poke(A_EPC,    32'h0);
        poke(A_BADV,   32'h0);
        set_exc(5'd4, 32'h8000_1000, 1'b0, 1'b1, 32'h1234_5679); c0 = cyc;
        push_wr(A_EPC,  32'h8000_1000, c0 + 2);
        push_wr(A_BADV, 32'h1234_5679, c0 + 3);
        tick(1); exc_valid = 1'b0;
        tick(2); reset = 1'b1;
        tick(1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_we",   {31'd0, cop0_we}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t6_no_redir", {31'd0, redirect_valid}, 32'd0);
            tick(1);
        end
        chk("t6_epc", regs[A_EPC], 32'h8000_1000);
        chk("t6_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
